// File: rtl/genius_core.sv
// rtl/genius_core.sv - Simon-style memory game engine: sequence growth, playback and press checking
module genius_core #(
  parameter int          CHANNELS      = 4,
  parameter int          MAX_LEN       = 16,
  parameter int          SHOW_TICKS    = 50_000_000,
  parameter int          GAP_TICKS     = 12_500_000,
  parameter int          TIMEOUT_TICKS = 250_000_000,
  parameter logic [15:0] SEED          = 16'hACE1,
  localparam int         CW            = $clog2(CHANNELS),
  localparam int         LW            = $clog2(MAX_LEN + 1)
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                start,
  input  logic [CHANNELS-1:0] btn,
  output logic [CHANNELS-1:0] lamp,
  output logic [LW-1:0]       level,
  output logic [2:0]          phase,
  output logic                win,
  output logic                lose
);

  // one timer serves all three waits, so it is sized for the longest of them
  localparam int TMAX_SG = (SHOW_TICKS > GAP_TICKS) ? SHOW_TICKS : GAP_TICKS;
  localparam int TMAX    = (TMAX_SG > TIMEOUT_TICKS) ? TMAX_SG : TIMEOUT_TICKS;
  localparam int TW      = $clog2(TMAX + 1);
  localparam logic [CHANNELS-1:0] ONE = {{(CHANNELS-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_ADD      = 3'd1,
    S_SHOW_ON  = 3'd2,
    S_SHOW_OFF = 3'd3,
    S_INPUT    = 3'd4,
    S_WIN      = 3'd5,
    S_LOSE     = 3'd6
  } state_t;

  state_t               state, state_d;
  logic [LW-1:0]        level_d;
  logic [LW-1:0]        idx, idx_d;
  logic [TW-1:0]        timer, timer_d;
  logic [15:0]          lfsr;
  logic                 mem_we;
  // depth rounded to a power of two so level/idx index it without truncation
  logic [CW-1:0]        mem [0:(1<<LW)-1];
  logic [CHANNELS-1:0]  exp_oh;
  logic                 last;

  assign exp_oh = ONE << mem[idx];
  assign last   = (idx == level - LW'(1));

  // free-running LFSR, taps x^16+x^14+x^13+x^11+1; runs in every state so start timing seeds the game
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) lfsr <= SEED;
    else          lfsr <= {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
  end

  // sequence memory: written once per round in ADD, read asynchronously, never cleared
  always_ff @(posedge clock) begin
    if (mem_we) mem[level] <= lfsr[CW-1:0];
  end

  // state, level, step index and timer registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
      level <= '0;
      idx   <= '0;
      timer <= '0;
    end else begin
      state <= state_d;
      level <= level_d;
      idx   <= idx_d;
      timer <= timer_d;
    end
  end

  // next-state logic: playback pacing, press checking, timeout and game outcome
  always_comb begin
    state_d = state;
    level_d = level;
    idx_d   = idx;
    timer_d = timer;
    mem_we  = 1'b0;
    case (state)
      S_IDLE, S_WIN, S_LOSE: begin
        if (start) begin
          level_d = '0;
          state_d = S_ADD;
        end
      end
      S_ADD: begin
        mem_we  = 1'b1;
        level_d = level + LW'(1);
        idx_d   = '0;
        timer_d = '0;
        state_d = S_SHOW_ON;
      end
      S_SHOW_ON: begin
        if (timer == TW'(SHOW_TICKS - 1)) begin
          timer_d = '0;
          state_d = S_SHOW_OFF;
        end else begin
          timer_d = timer + TW'(1);
        end
      end
      S_SHOW_OFF: begin
        if (timer == TW'(GAP_TICKS - 1)) begin
          timer_d = '0;
          if (last) begin
            idx_d   = '0;
            state_d = S_INPUT;
          end else begin
            idx_d   = idx + LW'(1);
            state_d = S_SHOW_ON;
          end
        end else begin
          timer_d = timer + TW'(1);
        end
      end
      S_INPUT: begin
        // a press in the timeout cycle wins over the timeout
        if (btn != '0) begin
          if (btn == exp_oh) begin
            if (!last) begin
              idx_d   = idx + LW'(1);
              timer_d = '0;
            end else if (level == LW'(MAX_LEN)) begin
              state_d = S_WIN;
            end else begin
              state_d = S_ADD;
            end
          end else begin
            state_d = S_LOSE;
          end
        end else if (timer == TW'(TIMEOUT_TICKS - 1)) begin
          state_d = S_LOSE;
        end else begin
          timer_d = timer + TW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // lamp decode: current playback step while showing, all lit on a win
  always_comb begin
    lamp = '0;
    case (state)
      S_SHOW_ON: lamp = exp_oh;
      S_WIN:     lamp = '1;
      default:   lamp = '0;
    endcase
  end

  assign phase = state;
  assign win   = (state == S_WIN);
  assign lose  = (state == S_LOSE);

endmodule

// File: tb/tb_genius_core.sv
// tb/tb_genius_core.sv - randomized scoreboard bench for genius_core
module tb_genius_core;
  localparam int CH = 4, ML = 4, ST = 3, GT = 2, TO = 20;
  localparam int SEEDV = 16'hACE1;

  logic       clock = 1'b0;
  logic       reset_n, start;
  logic [3:0] btn, lamp;
  logic [2:0] level, phase;
  logic       win, lose;

  genius_core #(.CHANNELS(CH), .MAX_LEN(ML), .SHOW_TICKS(ST), .GAP_TICKS(GT),
                .TIMEOUT_TICKS(TO), .SEED(16'hACE1)) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .btn(btn), .lamp(lamp),
    .level(level), .phase(phase), .win(win), .lose(lose));

  typedef struct { int c; int ph; int lv; int lm; int w; int l; } ev_t;
  ev_t         exp_q[$];
  ev_t         ev;
  int          cyc = 0;
  int          n_cmp = 0, n_err = 0;
  int          rel_cyc, in_cyc, d, a, p, pw, w;
  int          seq[4];
  bit          mon_en, done;
  logic [11:0] cur, prev;

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog expired at cyc=%0d", cyc);
    $fatal(1);
  end

  // LFSR state after n shifts from the seed: Fibonacci, taps 16,14,13,11
  function automatic int lfsr_after(input int n);
    int l = SEEDV;
    int b;
    for (int i = 0; i < n; i++) begin
      b = ((l >> 0) ^ (l >> 2) ^ (l >> 3) ^ (l >> 5)) & 1;
      l = (l >> 1) | (b << 15);
    end
    return l;
  endfunction

  task automatic chk(input string name, input int got, input int req);
    n_cmp++;
    if (got !== req) begin
      n_err++;
      $display("FAIL %s: got %0h required %0h", name, got, req);
    end
  endtask

  task automatic push(input int c, input int ph, input int lv, input int lm, input int wi, input int lo);
    exp_q.push_back('{c, ph, lv, lm, wi, lo});
  endtask

  task automatic goto(input int c);
    while (cyc < c) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic start_game(input int ac);
    goto(ac - 1);
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
  endtask

  task automatic press_at(input int pc, input logic [3:0] v);
    goto(pc - 1);
    btn = v;
    @(posedge clock); #1;
    btn = 4'b0;
  endtask

  // expected output events of a round whose ADD cycle is ac and new length is nl
  task automatic expect_round(input int ac, input int nl);
    seq[nl-1] = lfsr_after(ac - rel_cyc) % CH;
    push(ac, 1, nl - 1, 0, 0, 0);
    for (int i = 0; i < nl; i++) begin
      push(ac + 1 + 5 * i, 2, nl, 1 << seq[i], 0, 0);
      push(ac + 4 + 5 * i, 3, nl, 0, 0, 0);
    end
    push(ac + 1 + 5 * nl, 4, nl, 0, 0, 0);
    in_cyc = ac + 1 + 5 * nl;
  endtask

  // correct non-final presses (no visible output change); returns last press cycle
  task automatic press_seq(input int e, input int n, input int g0, output int pl);
    int pc = e;
    for (int i = 0; i < n; i++) begin
      pc = pc + ((i == 0 && g0 > 0) ? g0 : int'($urandom_range(1, 6)));
      press_at(pc, 4'(1 << seq[i]));
    end
    pl = pc;
  endtask

  task automatic correct_round(input int nl, input int g0, input int gl);
    int pl, pf;
    press_seq(in_cyc, nl - 1, g0, pl);
    pf = pl + ((gl > 0) ? gl : int'($urandom_range(1, 6)));
    if (nl < ML) expect_round(pf, nl + 1);
    else         push(pf, 5, nl, 15, 1, 0);
    press_at(pf, 4'(1 << seq[nl-1]));
  endtask

  task automatic do_reset();
    chk("queue_empty_before_reset", exp_q.size(), 0);
    mon_en  = 1'b0;
    reset_n = 1'b0;
    #1;
    chk("async_reset_outputs", int'({phase, level, lamp, win, lose}), 0);
    repeat (2) @(posedge clock);
    #1;
    chk("held_reset_outputs", int'({phase, level, lamp, win, lose}), 0);
    reset_n = 1'b1;
    rel_cyc = cyc;
    mon_en  = 1'b1;
  endtask

  initial begin
    reset_n = 1'b1; start = 1'b0; btn = 4'b0; mon_en = 1'b0; done = 1'b0; prev = '0;
    #2;
    fork
      begin
        while (!done) begin
          @(negedge clock);
          cur = {phase, level, lamp, win, lose};
          if (mon_en && cur !== prev) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
              n_err++;
              $display("FAIL unexpected_output cyc=%0d: got ph=%0d lv=%0d lamp=%b win=%b lose=%b, required no change",
                       cyc, phase, level, lamp, win, lose);
            end else begin
              ev = exp_q.pop_front();
              if (ev.c != cyc || ev.ph != int'(phase) || ev.lv != int'(level) ||
                  ev.lm != int'(lamp) || ev.w != int'(win) || ev.l != int'(lose)) begin
                n_err++;
                $display("FAIL event: got cyc=%0d ph=%0d lv=%0d lamp=%0h win=%0d lose=%0d required cyc=%0d ph=%0d lv=%0d lamp=%0h win=%0d lose=%0d",
                         cyc, phase, level, lamp, win, lose, ev.c, ev.ph, ev.lv, ev.lm, ev.w, ev.l);
              end
            end
          end
          prev = cur;
        end
      end
      begin
        // power-on reset, checked before any clock edge
        reset_n = 1'b0;
        #1;
        chk("reset_outputs", int'({phase, level, lamp, win, lose}), 0);
        repeat (3) @(posedge clock);
        #1;
        reset_n = 1'b1;
        rel_cyc = cyc;
        mon_en  = 1'b1;

        // buttons in IDLE are ignored
        p = cyc + 2;
        press_at(p, 4'($urandom_range(1, 15)));
        goto(p + 2);
        chk("idle_btn_ignored", int'({phase, level, lamp, win, lose}), 0);

        // game 1: full correct play to WIN, with boundary press timing and ignored show-time presses
        d = int'($urandom_range(8, 40));
        a = rel_cyc + d;
        expect_round(a, 1);
        start_game(a);
        press_at(a + 2, 4'($urandom_range(1, 15)));
        correct_round(1, 0, 0);
        correct_round(2, 20, 20);
        correct_round(3, 19, 0);
        correct_round(4, 0, 0);
        goto(cyc + 3);

        // game 2 from WIN: wrong channel on second press of round 2
        a = cyc + int'($urandom_range(2, 10));
        expect_round(a, 1);
        start_game(a);
        correct_round(1, 0, 0);
        press_seq(in_cyc, 1, 0, p);
        pw = p + int'($urandom_range(1, 6));
        w  = (seq[1] + int'($urandom_range(1, 3))) % CH;
        push(pw, 6, 2, 0, 0, 1);
        press_at(pw, 4'(1 << w));
        goto(pw + 3);

        // game 3 from LOSE: two-bit press on first press of round 2
        a = cyc + int'($urandom_range(2, 10));
        expect_round(a, 1);
        start_game(a);
        correct_round(1, 0, 0);
        pw = in_cyc + int'($urandom_range(1, 6));
        push(pw, 6, 2, 0, 0, 1);
        press_at(pw, 4'b0011);
        goto(pw + 3);

        // game 4: no press, timeout on the 20th edge
        a = cyc + int'($urandom_range(2, 10));
        expect_round(a, 1);
        start_game(a);
        push(in_cyc + TO, 6, 1, 0, 0, 1);
        goto(in_cyc + TO + 3);

        // game 5: reset in the middle of SHOW_ON
        do_reset();
        a = rel_cyc + d;
        seq[0] = lfsr_after(a - rel_cyc) % CH;
        push(a, 1, 0, 0, 0, 0);
        push(a + 1, 2, 1, 1 << seq[0], 0, 0);
        start_game(a);
        goto(a + 2);
        do_reset();

        // game 6: same start offset after reset, two rounds then timeout in round 3
        a = rel_cyc + d;
        expect_round(a, 1);
        start_game(a);
        correct_round(1, 0, 0);
        correct_round(2, 0, 0);
        push(in_cyc + TO, 6, 3, 0, 0, 1);
        goto(in_cyc + TO + 3);

        chk("queue_drained", exp_q.size(), 0);
        done = 1'b1;
      end
    join
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/genius_core.md
# genius_core

Parametrised game engine for the Genius (Simon) memory game: it grows a pseudo-random sequence of channel indices, plays it back on one-hot lamp outputs, and checks the player's button presses against it. It generalises the board-level Genius FSM to N channels, configurable maximum length, display timing and input timeout, and adds win/lose/timeout outcomes. It sits between the debounced button/switch front end and the LED and 7-segment drivers, which display `level` and `phase`.

## Interface

Parameters:

- CHANNELS, 4: number of colours/buttons; power of two, 2..8; CW = clog2(CHANNELS).
- MAX_LEN, 16: sequence length that wins; 2..64; LW = clog2(MAX_LEN+1).
- SHOW_TICKS, 50_000_000: clock cycles each lamp stays lit during playback; ≥1.
- GAP_TICKS, 12_500_000: dark cycles after each playback step; ≥1.
- TIMEOUT_TICKS, 250_000_000: idle cycles allowed per expected press; ≥2.
- SEED, 16'hACE1: LFSR reset value; non-zero.

Ports:

- clock  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle pulse; begins a new game.
- btn  in  CHANNELS  player buttons, debounced single-cycle pulses.
- lamp  out  CHANNELS  one-hot playback lamps.
- level  out  LW  current sequence length.
- phase  out  3  state code: IDLE=0, ADD=1, SHOW_ON=2, SHOW_OFF=3, INPUT=4, WIN=5, LOSE=6.
- win  out  1  high while in WIN.
- lose  out  1  high while in LOSE.

## Operation

- Reset (asynchronous, on reset_n low): phase=IDLE, lamp=0, level=0, win=0, lose=0, step index=0, timer=0, LFSR=SEED. Sequence memory is not cleared.
- LFSR: 16-bit Fibonacci, taps x^16+x^14+x^13+x^11+1, shifts every cycle in all states. New entries take lfsr[CW-1:0]. The sequence therefore depends on start timing.
- IDLE, WIN and LOSE: a start pulse sets level=0, clears win/lose and goes to ADD. Start is ignored in every other state.
- ADD (1 cycle): mem[level] ← lfsr[CW-1:0]; level ← level+1; idx ← 0; timer ← 0; next state SHOW_ON.
- SHOW_ON: lamp = onehot(mem[idx]). After SHOW_TICKS cycles, go to SHOW_OFF with timer ← 0.
- SHOW_OFF: lamp=0 for GAP_TICKS cycles. Then:
  - if idx = level-1: go to INPUT with idx ← 0, timer ← 0;
  - otherwise: idx ← idx+1 and go to SHOW_ON.
- Buttons are ignored in ADD, SHOW_ON, SHOW_OFF, IDLE, WIN and LOSE.
- INPUT, lamp=0, timer counts up each cycle. When btn≠0:
  - btn = onehot(mem[idx]) and idx < level-1: idx ← idx+1, timer ← 0.
  - btn = onehot(mem[idx]), idx = level-1 and level < MAX_LEN: go to ADD.
  - btn = onehot(mem[idx]), idx = level-1 and level = MAX_LEN: go to WIN.
  - any other non-zero btn (wrong channel, or more than one bit set): go to LOSE.
  - btn=0 with timer = TIMEOUT_TICKS-1: go to LOSE. A press in that same cycle takes priority over the timeout.
- WIN: win=1, lamp = all ones, level held.
- LOSE: lose=1, lamp=0, level held; level shows the round that failed.

## Timing

- All outputs are registered or decoded from registers only; there is no combinational path from input to output.
- Start sampled at edge k: phase=ADD after edge k. After edge k+1: phase=SHOW_ON, level=1, lamp valid.
- Each playback step occupies exactly SHOW_TICKS + GAP_TICKS cycles.
- A correct or incorrect press sampled at edge j takes effect after edge j (idx, phase, win/lose).
- Sequence memory read is asynchronous (distributed RAM); its write occurs at the ADD edge.
- reset_n low at any time, including mid-playback or mid-input, forces reset values immediately. Operation resumes in IDLE on the first edge after release.

## Test plan

Bench configuration: CHANNELS=4, MAX_LEN=4, SHOW_TICKS=3, GAP_TICKS=2, TIMEOUT_TICKS=20.

- Reset: assert reset_n=0 → lamp=0, level=0, phase=0, win=0, lose=0. Pressing btn in IDLE leaves all outputs unchanged.
- Start pulse: phase goes 1 then 2; lamp one-hot for exactly 3 cycles, 0 for 2 cycles; level=1; then phase=4. Correct press → level=2, two playback steps, first step identical to round 1.
- Full correct play through 4 rounds → phase=5, win=1, lamp=4'b1111, level=4. Start → win=0, level=1.
- Round 2: correct first press, wrong channel on second press → phase=6, lose=1, level=2, lamp=0. A two-bit btn (4'b0011) on the first press also → LOSE.
- INPUT with no press for 20 cycles → LOSE on the 20th edge. A correct press on cycle 19 → no LOSE and timer restarts. Buttons pressed during SHOW_ON are ignored.
- reset_n low in mid SHOW_ON → lamp=0, phase=0 asynchronously. After release, LFSR restarts from 16'hACE1; the same start cycle offset reproduces the same sequence.
